// File: rtl/array_rw_port_ctrl.sv
// Single-port RW0 array front end: round-robin write/read arbitration plus credit-managed
// response FIFO. Define ARRAY_RW_CTRL_PERF_EN to add saturating conflict/stall counters.
module array_rw_port_ctrl #(
    parameter int unsigned ADDR_W     = 3,
    parameter int unsigned DATA_W     = 30,
    parameter int unsigned SEG        = 2,
    parameter int unsigned RESP_DEPTH = 2
) (
    input  logic              clock,
    input  logic              reset,

    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [SEG-1:0]    wr_mask,
    input  logic [DATA_W-1:0] wr_data,

    input  logic              rd_valid,
    output logic              rd_ready,
    input  logic [ADDR_W-1:0] rd_addr,

    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_data,

    output logic [ADDR_W-1:0] RW0_addr,
    output logic              RW0_en,
    output logic              RW0_wmode,
    output logic [SEG-1:0]    RW0_wmask,
    output logic [DATA_W-1:0] RW0_wdata,
    input  logic [DATA_W-1:0] RW0_rdata
`ifdef ARRAY_RW_CTRL_PERF_EN
    ,
    output logic [15:0]       perf_conflict_cnt,
    output logic [15:0]       perf_credit_stall_cnt
`endif
);

    localparam int unsigned PTR_W = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(RESP_DEPTH + 1);

    logic              blk_q;
    logic              prefer_wr_q;
    logic              inflight_q;
    logic [CNT_W-1:0]  count_q;
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [DATA_W-1:0] fifo_q [RESP_DEPTH];

    logic active;
    logic credit_ok;
    logic rd_elig;
    logic contest;
    logic grant_wr;
    logic grant_rd;
    logic push;
    logic pop;

    // Grants are held off during reset and for one cycle after it.
    assign active    = !reset && !blk_q;
    assign credit_ok = (32'(count_q) + 32'(inflight_q)) < RESP_DEPTH;
    assign rd_elig   = rd_valid && credit_ok;
    assign contest   = active && wr_valid && rd_elig;

    always_comb begin
        grant_wr = 1'b0;
        grant_rd = 1'b0;
        if (active) begin
            if (wr_valid && rd_elig) begin
                if (prefer_wr_q) begin
                    grant_wr = 1'b1;
                end else begin
                    grant_rd = 1'b1;
                end
            end else if (wr_valid) begin
                grant_wr = 1'b1;
            end else if (rd_elig) begin
                grant_rd = 1'b1;
            end
        end
    end

    always_comb begin
        wr_ready  = grant_wr;
        rd_ready  = grant_rd;
        RW0_en    = grant_wr || grant_rd;
        RW0_wmode = grant_wr;
        RW0_addr  = '0;
        RW0_wmask = '0;
        RW0_wdata = '0;
        if (grant_wr) begin
            RW0_addr  = wr_addr;
            RW0_wmask = wr_mask;
            RW0_wdata = wr_data;
        end else if (grant_rd) begin
            RW0_addr  = rd_addr;
        end
    end

    // Read data lands one cycle after issue; the credit check guarantees a free slot.
    assign push       = inflight_q;
    assign resp_valid = !reset && (count_q != '0);
    assign resp_data  = fifo_q[rd_ptr_q];
    assign pop        = resp_valid && resp_ready;

    always_ff @(posedge clock) begin
        if (reset) begin
            blk_q       <= 1'b1;
            prefer_wr_q <= 1'b1;
            inflight_q  <= 1'b0;
            count_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
        end else begin
            blk_q      <= 1'b0;
            inflight_q <= grant_rd;
            if (contest) begin
                prefer_wr_q <= !grant_wr;
            end
            if (push) begin
                wr_ptr_q <= (wr_ptr_q == PTR_W'(RESP_DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= (rd_ptr_q == PTR_W'(RESP_DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset && push) begin
            fifo_q[wr_ptr_q] <= RW0_rdata;
        end
    end

    a_push_has_space: assert property (@(posedge clock) disable iff (reset)
        inflight_q |-> (32'(count_q) < RESP_DEPTH));

`ifdef ARRAY_RW_CTRL_PERF_EN
    logic [15:0] conflict_q;
    logic [15:0] stall_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            conflict_q <= '0;
            stall_q    <= '0;
        end else begin
            if (contest && (conflict_q != 16'hFFFF)) begin
                conflict_q <= conflict_q + 16'd1;
            end
            if (rd_valid && !credit_ok && (stall_q != 16'hFFFF)) begin
                stall_q <= stall_q + 16'd1;
            end
        end
    end

    assign perf_conflict_cnt     = conflict_q;
    assign perf_credit_stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_array_rw_port_ctrl.sv
// Randomized self-checking bench for array_rw_port_ctrl with a transaction-level reference
// model and a behavioural model of the RW0 array macro.
module tb_array_rw_port_ctrl;

    localparam int unsigned ADDR_W     = 3;
    localparam int unsigned DATA_W     = 30;
    localparam int unsigned SEG        = 2;
    localparam int unsigned RESP_DEPTH = 2;
    localparam int unsigned SEG_W      = DATA_W / SEG;

    logic              clock = 1'b0;
    logic              reset;
    logic              wr_valid;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [SEG-1:0]    wr_mask;
    logic [DATA_W-1:0] wr_data;
    logic              rd_valid;
    logic              rd_ready;
    logic [ADDR_W-1:0] rd_addr;
    logic              resp_valid;
    logic              resp_ready;
    logic [DATA_W-1:0] resp_data;
    logic [ADDR_W-1:0] RW0_addr;
    logic              RW0_en;
    logic              RW0_wmode;
    logic [SEG-1:0]    RW0_wmask;
    logic [DATA_W-1:0] RW0_wdata;
    logic [DATA_W-1:0] RW0_rdata;
`ifdef ARRAY_RW_CTRL_PERF_EN
    logic [15:0]       perf_conflict_cnt;
    logic [15:0]       perf_credit_stall_cnt;
`endif

    always #5 clock = ~clock;

    array_rw_port_ctrl #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .SEG       (SEG),
        .RESP_DEPTH(RESP_DEPTH)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_addr   (wr_addr),
        .wr_mask   (wr_mask),
        .wr_data   (wr_data),
        .rd_valid  (rd_valid),
        .rd_ready  (rd_ready),
        .rd_addr   (rd_addr),
        .resp_valid(resp_valid),
        .resp_ready(resp_ready),
        .resp_data (resp_data),
        .RW0_addr  (RW0_addr),
        .RW0_en    (RW0_en),
        .RW0_wmode (RW0_wmode),
        .RW0_wmask (RW0_wmask),
        .RW0_wdata (RW0_wdata),
        .RW0_rdata (RW0_rdata)
`ifdef ARRAY_RW_CTRL_PERF_EN
        ,
        .perf_conflict_cnt    (perf_conflict_cnt),
        .perf_credit_stall_cnt(perf_credit_stall_cnt)
`endif
    );

    // Array macro: masked write, 1-cycle registered read.
    logic [DATA_W-1:0] arr [2**ADDR_W];
    always @(posedge clock) begin
        if (RW0_en) begin
            if (RW0_wmode) begin
                for (int s = 0; s < int'(SEG); s++) begin
                    if (RW0_wmask[s]) arr[RW0_addr][s*SEG_W +: SEG_W] <= RW0_wdata[s*SEG_W +: SEG_W];
                end
            end else begin
                RW0_rdata <= arr[RW0_addr];
            end
        end
    end

    // Reference model state
    logic [DATA_W-1:0] ref_mem [2**ADDR_W];
    logic [DATA_W-1:0] resp_q [$];
    bit                m_inflight;
    logic [DATA_W-1:0] m_inflight_data;
    bit                m_pref_wr;
    bit                m_blk;
    int                m_conf;
    int                m_stall;

    int n_tests;
    int n_fail;

    logic              obs_en;
    logic              obs_wmode;
    logic              obs_rd_hs;
    logic              obs_resp_valid;
    logic [DATA_W-1:0] obs_resp_data;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock: compare outputs at the falling edge, then advance the model at the rising edge.
    task automatic cycle();
        bit                credit;
        bit                elig;
        bit                contest;
        bit                gw;
        bit                gr;
        bit                active;
        bit                exp_rv;
        bit                pop;
        logic [63:0]       exp_port;
        logic [63:0]       got_port;
        logic [DATA_W-1:0] bits;
        @(negedge clock);
        active  = !reset && !m_blk;
        credit  = (resp_q.size() + int'(m_inflight)) < int'(RESP_DEPTH);
        elig    = rd_valid && credit;
        contest = active && wr_valid && elig;
        gw      = active && wr_valid && (!elig || m_pref_wr);
        gr      = active && elig && !gw;
        exp_port = '0;
        if (gw) exp_port = {1'b1, 1'b0, 1'b1, 1'b1, wr_addr, wr_mask, wr_data};
        else if (gr) exp_port = {1'b0, 1'b1, 1'b1, 1'b0, rd_addr, {SEG{1'b0}}, {DATA_W{1'b0}}};
        got_port = {wr_ready, rd_ready, RW0_en, RW0_wmode, RW0_en ? RW0_addr : {ADDR_W{1'b0}},
                    RW0_wmask, RW0_wdata};
        check("port", got_port, exp_port);
        exp_rv = !reset && (resp_q.size() > 0);
        check("resp", {resp_valid, resp_valid ? resp_data : {DATA_W{1'b0}}},
              {exp_rv, exp_rv ? resp_q[0] : {DATA_W{1'b0}}});
`ifdef ARRAY_RW_CTRL_PERF_EN
        if (!reset) begin
            check("perf", {perf_conflict_cnt, perf_credit_stall_cnt},
                  {m_conf[15:0], m_stall[15:0]});
        end
`endif
        obs_en         = RW0_en;
        obs_wmode      = RW0_wmode;
        obs_rd_hs      = rd_valid && rd_ready;
        obs_resp_valid = resp_valid;
        obs_resp_data  = resp_data;
        pop = exp_rv && resp_ready;
        @(posedge clock);
        if (reset) begin
            resp_q.delete();
            m_inflight = 0;
            m_pref_wr  = 1;
            m_blk      = 1;
            m_conf     = 0;
            m_stall    = 0;
        end else begin
            m_blk = 0;
            if (rd_valid && !credit && m_stall < 65535) m_stall++;
            if (contest) begin
                if (m_conf < 65535) m_conf++;
                m_pref_wr = !gw;
            end
            if (pop) void'(resp_q.pop_front());
            if (m_inflight) resp_q.push_back(m_inflight_data);
            m_inflight = gr;
            if (gr) m_inflight_data = ref_mem[rd_addr];
            if (gw) begin
                bits = {{SEG_W{wr_mask[1]}}, {SEG_W{wr_mask[0]}}};
                ref_mem[wr_addr] = (ref_mem[wr_addr] & ~bits) | (wr_data & bits);
            end
        end
        #1;
    endtask

    task automatic idle_inputs();
        wr_valid = 0;
        rd_valid = 0;
    endtask

    initial begin
        int hs;
        int en_cnt;
        logic [5:0] pat;
        bit seen;

        n_tests = 0;
        n_fail  = 0;
        for (int i = 0; i < 2**ADDR_W; i++) begin
            arr[i]     = '0;
            ref_mem[i] = '0;
        end
        m_inflight = 0;
        m_inflight_data = '0;
        m_pref_wr = 1;
        m_blk = 1;
        m_conf = 0;
        m_stall = 0;
        reset = 1; wr_valid = 1; rd_valid = 1; resp_ready = 1;
        wr_addr = '0; wr_mask = '0; wr_data = '0; rd_addr = '0;
        #1;

        // Reset and the blocked cycle after it
        repeat (2) cycle();
        reset = 0;
        cycle();
        check("post_reset_no_grant", obs_en, 1'b0);

        // Write then read
        rd_valid = 0; wr_valid = 1; wr_addr = 3; wr_mask = 2'b11; wr_data = 30'h1234_5678;
        cycle();
        wr_valid = 0; rd_valid = 1; rd_addr = 3;
        cycle();
        check("wr_rd_handshake", obs_rd_hs, 1'b1);
        rd_valid = 0;
        cycle();
        check("wr_rd_lat1", obs_resp_valid, 1'b0);
        cycle();
        check("wr_rd_data", {obs_resp_valid, obs_resp_data}, {1'b1, 30'h1234_5678});

        // Partial mask
        wr_valid = 1; wr_addr = 5; wr_mask = 2'b11; wr_data = 30'h3FFF_FFFF;
        cycle();
        wr_mask = 2'b01; wr_data = '0;
        cycle();
        wr_valid = 0; rd_valid = 1; rd_addr = 5;
        cycle();
        rd_valid = 0;
        repeat (2) cycle();
        check("partial_mask", {obs_resp_valid, obs_resp_data}, {1'b1, 30'h3FFF_8000});

        // Contention after reset: W,R,W,R,W,R
        reset = 1; cycle();
        reset = 0; idle_inputs(); cycle();
        wr_valid = 1; rd_valid = 1; resp_ready = 1;
        pat = '0; en_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            wr_addr = ADDR_W'($urandom); wr_mask = SEG'($urandom); wr_data = DATA_W'($urandom);
            rd_addr = ADDR_W'($urandom);
            cycle();
            pat = {pat[4:0], obs_wmode};
            en_cnt += int'(obs_en);
        end
        check("contention_wmode", pat, 6'b101010);
        check("contention_en", en_cnt, 6);
        idle_inputs();
        repeat (3) cycle();

        // Backpressure: only RESP_DEPTH reads accepted, head held
        resp_ready = 0; rd_valid = 1; hs = 0; seen = 0;
        for (int i = 0; i < 6; i++) begin
            rd_addr = ADDR_W'($urandom);
            cycle();
            hs += int'(obs_rd_hs);
        end
        check("bp_accepted", hs, 2);
        check("bp_last_rd_ready", obs_rd_hs, 1'b0);
        resp_ready = 1;
        repeat (6) begin
            rd_addr = ADDR_W'($urandom);
            cycle();
        end
        idle_inputs();
        repeat (4) cycle();

        // Reset the cycle after a read issue
        rd_valid = 1; rd_addr = 3;
        cycle();
        check("midflight_issue", obs_rd_hs, 1'b1);
        rd_valid = 0; reset = 1;
        cycle();
        reset = 0; seen = 0;
        repeat (5) begin
            cycle();
            seen |= obs_resp_valid;
        end
        check("midflight_no_resp", seen, 1'b0);

`ifdef ARRAY_RW_CTRL_PERF_EN
        reset = 1; cycle();
        reset = 0; idle_inputs(); resp_ready = 1; cycle();
        wr_valid = 1; rd_valid = 1;
        repeat (4) cycle();
        wr_valid = 0; resp_ready = 0;
        repeat (4) cycle();
        check("perf_conflict", perf_conflict_cnt, 16'd4);
        check("perf_stall", perf_credit_stall_cnt, 16'd3);
        rd_valid = 0; resp_ready = 1;
        repeat (4) cycle();
`endif

        // Random traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            reset      = ($urandom_range(99) == 0);
            wr_valid   = 1'($urandom);
            rd_valid   = 1'($urandom);
            resp_ready = ($urandom_range(3) != 0);
            wr_addr    = ADDR_W'($urandom);
            wr_mask    = SEG'($urandom);
            wr_data    = DATA_W'($urandom);
            rd_addr    = ADDR_W'($urandom);
            cycle();
        end
        reset = 0; idle_inputs(); resp_ready = 1;
        repeat (5) cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/array_rw_port_ctrl.md
Name: array_rw_port_ctrl

Overview:
- Upstream controller for the 8x30 single-port, 2-segment write-masked array macro (one shared RW0 port, 1-cycle read latency).
- Accepts independent write and read request channels (valid/ready) and arbitrates them round-robin onto the single port.
- Captures array read data into a small response FIFO with credit-based flow control, so backpressure never loses data.

Parameters:
- ADDR_W, 3, array address width (depth 2^ADDR_W).
- DATA_W, 30, array word width.
- SEG, 2, mask segments; segment width DATA_W/SEG (15). DATA_W must be divisible by SEG.
- RESP_DEPTH, 2, response FIFO entries; minimum 1.

Ports:
- clock  in  1  sole clock.
- reset  in  1  synchronous, active-high.
- wr_valid  in  1  write request valid.
- wr_ready  out  1  write accepted this cycle.
- wr_addr  in  ADDR_W  write address.
- wr_mask  in  SEG  per-segment write enable.
- wr_data  in  DATA_W  write data.
- rd_valid  in  1  read request valid.
- rd_ready  out  1  read accepted this cycle.
- rd_addr  in  ADDR_W  read address.
- resp_valid  out  1  read response valid.
- resp_ready  in  1  consumer accepts response.
- resp_data  out  DATA_W  read response data.
- RW0_addr  out  ADDR_W  array address.
- RW0_en  out  1  array enable.
- RW0_wmode  out  1  1 = write, 0 = read.
- RW0_wmask  out  SEG  array write mask.
- RW0_wdata  out  DATA_W  array write data.
- RW0_rdata  in  DATA_W  array read data, valid the cycle after a read issue.

Behaviour:
- Reset is synchronous, active-high. While reset is high and on the first cycle after it:
  - wr_ready=0, rd_ready=0, RW0_en=0, resp_valid=0.
  - FIFO empty, in-flight flag cleared, round-robin pointer set to favour write.
- Credit rule: a read is eligible only if fifo_count + inflight < RESP_DEPTH. inflight is 1 in the cycle after a read issue.
- Arbitration, combinational, at most one grant per cycle:
  - Only wr_valid: grant write.
  - Only eligible read: grant read.
  - Both: grant the side not granted last time both competed. The pointer updates only on a contested grant.
- Write grant:
  - wr_ready=1; RW0_en=1; RW0_wmode=1.
  - RW0_addr/wmask/wdata = wr_addr/wr_mask/wr_data.
  - A wr_mask of all zeros is still issued and consumes the slot.
- Read grant:
  - rd_ready=1; RW0_en=1; RW0_wmode=0; RW0_addr=rd_addr.
  - RW0_wmask=0 and RW0_wdata=0 during reads and idle.
- No grant: RW0_en=0, wr_ready=0, rd_ready=0.
- Read latency:
  - RW0_rdata is pushed into the FIFO on the cycle after issue, unconditionally (the credit guarantees space).
  - resp_valid asserts at the earliest 2 cycles after the rd_valid&rd_ready handshake. There is no bypass.
- FIFO:
  - In-order, push and pop allowed in the same cycle.
  - resp_valid = !empty; resp_data = head entry, held stable while resp_valid && !resp_ready.
  - A pop frees a credit, visible to eligibility the next cycle.
- Ordering: a read observes every write granted in a strictly earlier cycle. The relative order of a same-cycle pending read and write follows arbitration.
- Reset mid-operation: an in-flight read and FIFO contents are discarded; no response is produced for them.

Optional Feature:
- Macro: ARRAY_RW_CTRL_PERF_EN.
- When defined, adds outputs perf_conflict_cnt [15:0] and perf_credit_stall_cnt [15:0]:
  - perf_conflict_cnt increments on each cycle where wr_valid and an eligible read compete.
  - perf_credit_stall_cnt increments on each cycle where rd_valid=1 but the read is credit-ineligible.
  - Both saturate at 16'hFFFF and reset to 0.
- When undefined, neither port nor logic exists, and port-level behaviour is otherwise identical.

Test Plan:
- Write then read: write addr 3, mask 2'b11, data 30'h1234_5678 → next-cycle read of addr 3 gives resp_valid 2 cycles after its handshake, resp_data=30'h1234_5678.
- Partial mask: write addr 5 with data 30'h3FFF_FFFF, mask 2'b11; then write data 0, mask 2'b01 → read addr 5 returns 30'h3FFF_8000.
- Contention: wr_valid and rd_valid held high for 6 cycles → grants alternate W,R,W,R,W,R starting with W after reset; RW0_wmode toggles 1,0,1,0,1,0.
- Backpressure: resp_ready=0, rd_valid held high with RESP_DEPTH=2 → exactly 2 reads accepted, then rd_ready=0, and resp_data holds the first entry. Raising resp_ready drains in order, and reads resume one cycle after each pop.
- Reset mid-flight: assert reset the cycle after a read issue → resp_valid stays 0 after reset; no stale response.
- With ARRAY_RW_CTRL_PERF_EN: 4 contested cycles and 3 credit-stalled cycles → perf_conflict_cnt=4, perf_credit_stall_cnt=3.
